dmem_arbiter: RTL and testbench

- Shares the single-port DataMemory between two requesters: port 0 is the CPU load/store path, port 1 is the program loader/DMA path.
- Arbitrates per cycle with round-robin priority.
- Drives the memory's A/WD/WE inputs and returns registered read data with a valid strobe one cycle after grant.
- Sits between the core datapath and dmem; the core stalls on a lost grant.

---
 rtl/dmem_arbiter_if.sv | 47 ++++
 rtl/dmem_arbiter.sv | 127 ++++++++++++
 tb/tb_dmem_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two DataMemory requesters, the arbiter and the memory.
// DMEM_ARB_LOCK_EN adds the lock0/lock1 burst-lock request lines.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          rvalid0;
  logic [DW-1:0] rdata0;
  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          rvalid1;
  logic [DW-1:0] rdata1;
  logic [AW-1:0] mem_A;
  logic [DW-1:0] mem_WD;
  logic          mem_WE;
  logic [DW-1:0] mem_RD;
`ifdef DMEM_ARB_LOCK_EN
  logic          lock0;
  logic          lock1;

  modport master (
    output req0, we0, addr0, wdata0, lock0, req1, we1, addr1, wdata1, lock1, mem_RD,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, mem_A, mem_WD, mem_WE
  );
  modport slave (
    input  req0, we0, addr0, wdata0, lock0, req1, we1, addr1, wdata1, lock1, mem_RD,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, mem_A, mem_WD, mem_WE
  );
`else
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_RD,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, mem_A, mem_WD, mem_WE
  );
  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_RD,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, mem_A, mem_WD, mem_WE
  );
`endif
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port DataMemory.
// Optional locked bursts are enabled with the DMEM_ARB_LOCK_EN macro.
module dmem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input logic          CLK,
  input logic          RST,
  dmem_arbiter_if.slave bus
);

  logic          gnt0, gnt1, any_gnt;
  logic          prio_q, prio_d;
  logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

`ifdef DMEM_ARB_LOCK_EN
  logic locked_q, locked_d;
  logic owner_q, owner_d;
  logic owner_req, owner_lock, win_lock;

  assign owner_req  = owner_q ? bus.req1  : bus.req0;
  assign owner_lock = owner_q ? bus.lock1 : bus.lock0;
  assign win_lock   = (gnt0 & bus.lock0) | (gnt1 & bus.lock1);
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (bus.req0 && bus.req1) begin
      gnt0 = ~prio_q;
      gnt1 = prio_q;
    end else begin
      gnt0 = bus.req0;
      gnt1 = bus.req1;
    end
`ifdef DMEM_ARB_LOCK_EN
    // A requesting lock owner overrides round-robin.
    if (locked_q && owner_req) begin
      gnt0 = ~owner_q;
      gnt1 = owner_q;
    end
`endif
  end

  assign any_gnt = gnt0 | gnt1;

  always_comb begin
    bus.mem_A  = '0;
    bus.mem_WD = '0;
    bus.mem_WE = 1'b0;
    if (gnt0) begin
      bus.mem_A  = bus.addr0;
      bus.mem_WD = bus.wdata0;
      bus.mem_WE = bus.we0;
    end else if (gnt1) begin
      bus.mem_A  = bus.addr1;
      bus.mem_WD = bus.wdata1;
      bus.mem_WE = bus.we1;
    end
  end

  always_comb begin
    prio_d    = prio_q;
    rvalid0_d = gnt0 & ~bus.we0;
    rvalid1_d = gnt1 & ~bus.we1;
    rdata0_d  = rvalid0_d ? bus.mem_RD : rdata0_q;
    rdata1_d  = rvalid1_d ? bus.mem_RD : rdata1_q;
    // Next favoured port is the loser, i.e. port 1 exactly when port 0 won.
    if (any_gnt) begin
      prio_d = gnt0;
    end
`ifdef DMEM_ARB_LOCK_EN
    if (locked_q) begin
      prio_d = prio_q;
    end
`endif
  end

`ifdef DMEM_ARB_LOCK_EN
  always_comb begin
    locked_d = locked_q;
    owner_d  = owner_q;
    if (locked_q && (!owner_req || !owner_lock)) begin
      locked_d = 1'b0;
    end
    if (any_gnt && win_lock) begin
      locked_d = 1'b1;
      owner_d  = gnt1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      locked_q <= 1'b0;
      owner_q  <= 1'b0;
    end else begin
      locked_q <= locked_d;
      owner_q  <= owner_d;
    end
  end
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prio_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      prio_q    <= prio_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus randomized bench for dmem_arbiter against a cycle-level reference model
// built from the arbitration rules and a shadow copy of the memory.
module tb_dmem_arbiter;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  always #5 CLK = ~CLK;

  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // DataMemory: combinational read, write at the rising edge, upper address bits ignored.
  logic [31:0] tb_mem [64];
  assign bus.mem_RD = tb_mem[bus.mem_A[7:2]];
  always @(posedge CLK) begin
    if (bus.mem_WE) tb_mem[bus.mem_A[7:2]] <= bus.mem_WD;
  end

  // Reference model state.
  logic [31:0] ref_mem [64];
  int          m_prio;
  int          m_win;
  logic        exp_rv [2];
  logic [31:0] exp_rd [2];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0,
                       input logic [31:0] d0, input logic r1, input logic w1,
                       input logic [31:0] a1, input logic [31:0] d1);
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
  endtask

  task automatic model_reset();
    m_prio = 0;
    m_win  = -1;
    for (int p = 0; p < 2; p++) begin
      exp_rv[p] = 1'b0;
      exp_rd[p] = '0;
    end
  endtask

  // Called at posedge+1 with inputs applied; checks mid-cycle then advances one clock.
  task automatic cycle();
    logic        r [2];
    logic        w [2];
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic [31:0] e_a, e_d;
    logic        e_we;
    r[0] = bus.req0; w[0] = bus.we0; a[0] = bus.addr0; d[0] = bus.wdata0;
    r[1] = bus.req1; w[1] = bus.we1; a[1] = bus.addr1; d[1] = bus.wdata1;
    #3;
    if (r[0] && r[1]) m_win = m_prio;
    else if (r[0])    m_win = 0;
    else if (r[1])    m_win = 1;
    else              m_win = -1;
    e_a = '0; e_d = '0; e_we = 1'b0;
    if (m_win >= 0) begin
      e_a = a[m_win]; e_d = d[m_win]; e_we = w[m_win];
    end
    check_eq("gnt0",    {31'b0, bus.gnt0},    {31'b0, m_win == 0});
    check_eq("gnt1",    {31'b0, bus.gnt1},    {31'b0, m_win == 1});
    check_eq("mem_WE",  {31'b0, bus.mem_WE},  {31'b0, e_we});
    check_eq("mem_A",   bus.mem_A,            e_a);
    check_eq("mem_WD",  bus.mem_WD,           e_d);
    check_eq("rvalid0", {31'b0, bus.rvalid0}, {31'b0, exp_rv[0]});
    check_eq("rvalid1", {31'b0, bus.rvalid1}, {31'b0, exp_rv[1]});
    check_eq("rdata0",  bus.rdata0,           exp_rd[0]);
    check_eq("rdata1",  bus.rdata1,           exp_rd[1]);
    exp_rv[0] = 1'b0;
    exp_rv[1] = 1'b0;
    if (m_win >= 0) begin
      m_prio = 1 - m_win;
      if (w[m_win]) begin
        ref_mem[a[m_win][7:2]] = d[m_win];
      end else begin
        exp_rv[m_win] = 1'b1;
        exp_rd[m_win] = ref_mem[a[m_win][7:2]];
      end
    end
    @(posedge CLK);
    #1;
  endtask

  logic        rr [2];
  logic        rw [2];
  logic [31:0] ra [2];
  logic [31:0] rd [2];

  initial begin
    for (int i = 0; i < 64; i++) begin
      tb_mem[i]  = 32'h1000_0000 + i;
      ref_mem[i] = 32'h1000_0000 + i;
    end
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef DMEM_ARB_LOCK_EN
    bus.lock0 = 1'b0;
    bus.lock1 = 1'b0;
`endif
    #3;
    check_eq("rst_rvalid0", {31'b0, bus.rvalid0}, 32'd0);
    check_eq("rst_rvalid1", {31'b0, bus.rvalid1}, 32'd0);
    check_eq("rst_rdata0",  bus.rdata0,           32'd0);
    check_eq("rst_rdata1",  bus.rdata1,           32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b1;

    // Store then load through port 0.
    drive(1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0); cycle();
    drive(1, 0, 32'h10, 32'h0, 0, 0, 0, 0);         cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);                  cycle();
    check_eq("rd_deadbeef", bus.rdata0, 32'hDEAD_BEEF);

    // Continuous contention alternates grants.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 32'h20 + 4 * i, 0, 1, 0, 32'h40 + 4 * i, 0);
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0); cycle();

    // Lone port 1 streams, then port 0 is favoured.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1, 0, 32'h80 + 4 * i, 0);
      cycle();
    end
    drive(1, 0, 32'h14, 0, 1, 0, 32'h18, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);           cycle();

    // Reset while a port 1 read is in flight.
    drive(0, 0, 0, 0, 1, 0, 32'h10, 0);
    #3;
    RST = 1'b0;
    #1;
    check_eq("rst_mid_rvalid1", {31'b0, bus.rvalid1}, 32'd0);
    check_eq("rst_mid_rdata1",  bus.rdata1,           32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);           cycle();
    drive(1, 0, 32'h24, 0, 1, 0, 32'h28, 0); cycle();

    // Port 1 write dropped before it is ever granted.
    drive(0, 0, 0, 0, 1, 0, 32'h30, 0);                  cycle();
    drive(1, 0, 32'h34, 0, 1, 1, 32'h30, 32'hBAD0_BAD0); cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);                       cycle();
    drive(1, 0, 32'h30, 0, 0, 0, 0, 0);                  cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);                       cycle();
    check_eq("drop_no_write", bus.rdata0, 32'h1000_000C);

    // Random traffic: a pending request is held until granted unless it is dropped.
    for (int p = 0; p < 2; p++) begin
      rr[p] = 1'b0; rw[p] = 1'b0; ra[p] = '0; rd[p] = '0;
    end
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!rr[p] || m_win == p || $urandom_range(0, 5) == 0) begin
          rr[p] = ($urandom_range(0, 3) != 0);
          rw[p] = $urandom_range(0, 1) == 1;
          ra[p] = $urandom;
          rd[p] = $urandom;
        end
      end
      drive(rr[0], rw[0], ra[0], rd[0], rr[1], rw[1], ra[1], rd[1]);
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
